// File: rtl/prefix_adder_pipe.sv
// ---------------------------------------------------------------------------
// prefix_adder_pipe
//
// Fully pipelined Kogge-Stone adder/subtractor with a valid/ready handshake
// on both sides and a sideband tag that travels with every operation.
//
// Pipeline:
//   S0            : per-bit generate/propagate of a and b' (b' = ~b for
//                   subtraction), with the effective carry-in folded into
//                   the bit-0 generate.
//   S1..S(LEVELS) : one Kogge-Stone prefix level each, span 2^(k-1).
//   OUT           : sum / cout / ovf / out_tag output register.
// Latency is LEVELS+1 edges from acceptance to out_valid (6 at WIDTH=32).
// All stages advance together when adv = !out_valid | out_ready, so a
// stalled consumer freezes the whole pipe and in_ready simply mirrors adv.
//
// Optional feature (build macro PREFIX_ADDER_SAT_EN):
//   defined   : on signed overflow sum saturates to 0x7F..F / 0x80..0
//   undefined : sum wraps modulo 2^WIDTH
//   ovf, cout and latency are identical in both builds.
//
// Parameters:
//   WIDTH  operand width, power of two, 4..64
//   TAG_W  sideband tag width
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous clear of all in-flight operations (beats accept)
//   in_valid   operand presented          in_ready   operand accepted
//   a, b       operands                   cin        carry-in (add only)
//   sub        0: a+b+cin, 1: a-b         in_tag     tag returned unchanged
//   out_valid  result present             out_ready  consumer takes result
//   sum        result                     cout       carry out of MSB
//   ovf        signed overflow            out_tag    tag of the result
// ---------------------------------------------------------------------------
module prefix_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int HALF   = WIDTH / 2;

    // ------------------------------------------------------------------
    // Stage registers. Index 0 is S0, index k is prefix level k.
    // g : group generate (with carry-in folded in at bit 0)
    // p : group propagate; the last level needs no propagate output
    // x : per-bit half sum a ^ b', carried unchanged to the output
    // c0: effective carry-in, needed for sum bit 0
    // ------------------------------------------------------------------
    logic [LEVELS:0]                v_q,   v_d;
    logic [LEVELS:0][WIDTH-1:0]     g_q,   g_d;
    logic [LEVELS-1:0][WIDTH-1:0]   p_q,   p_d;
    logic [LEVELS:0][WIDTH-1:0]     x_q,   x_d;
    logic [LEVELS:0]                c0_q,  c0_d;
    logic [LEVELS:0][TAG_W-1:0]     tag_q, tag_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_raw;
    int               span;
    int               lo;

    // At the last level the low half of the prefix tree is already
    // resolved, so its group propagate has no consumer; this sink keeps
    // the intent explicit and lets synthesis trim those flops.
    logic p_low_unused;
    assign p_low_unused = ^p_q[LEVELS-1][HALF-1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first, so no path through
        // this block can leave a value unassigned and infer a latch.
        adv         = !out_valid_q || out_ready;
        b_eff       = sub ? ~b : b;
        c_eff       = sub | cin;
        span        = 0;
        lo          = 0;

        v_d         = v_q;
        g_d         = g_q;
        p_d         = p_q;
        x_d         = x_q;
        c0_d        = c0_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_tag_d   = out_tag_q;

        // Carry into bit i is the final group generate of bits i-1..0.
        carry   = {g_q[LEVELS], c0_q[LEVELS]};
        sum_raw = x_q[LEVELS] ^ carry[WIDTH-1:0];

        if (adv) begin
            // S0: generate/propagate, carry-in folded into bit 0.
            v_d[0]    = in_valid;
            g_d[0]    = a & b_eff;
            p_d[0]    = a ^ b_eff;
            x_d[0]    = a ^ b_eff;
            g_d[0][0] = (a[0] & b_eff[0]) | ((a[0] ^ b_eff[0]) & c_eff);
            c0_d[0]   = c_eff;
            tag_d[0]  = in_tag;

            // S1..S(LEVELS): combine each position with the one span below.
            for (int k = 1; k <= LEVELS; k++) begin
                span     = 1 << (k - 1);
                v_d[k]   = v_q[k-1];
                x_d[k]   = x_q[k-1];
                c0_d[k]  = c0_q[k-1];
                tag_d[k] = tag_q[k-1];
                for (int i = 0; i < WIDTH; i++) begin
                    lo = (i >= span) ? i - span : 0;
                    if (i >= span) begin
                        g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][lo]);
                    end else begin
                        g_d[k][i] = g_q[k-1][i];
                    end
                end
            end

            for (int k = 1; k < LEVELS; k++) begin
                span = 1 << (k - 1);
                for (int i = 0; i < WIDTH; i++) begin
                    lo = (i >= span) ? i - span : 0;
                    if (i >= span) begin
                        p_d[k][i] = p_q[k-1][i] & p_q[k-1][lo];
                    end else begin
                        p_d[k][i] = p_q[k-1][i];
                    end
                end
            end

            // Output register.
            out_valid_d = v_q[LEVELS];
            out_tag_d   = tag_q[LEVELS];
            cout_d      = carry[WIDTH];
            ovf_d       = carry[WIDTH-1] ^ carry[WIDTH];
`ifdef PREFIX_ADDER_SAT_EN
            // On overflow the wrapped sign is the opposite of the true sign:
            // a wrapped negative means positive overflow.
            if (ovf_d) begin
                sum_d = sum_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                sum_d = sum_raw;
            end
`else
            sum_d = sum_raw;
`endif
        end

        // Flush wins over everything, including a stalled output and an
        // operand being accepted on the same edge.
        if (flush) begin
            v_d         = '0;
            out_valid_d = 1'b0;
        end
    end

    assign in_ready = adv;

    // ------------------------------------------------------------------
    // Control and output registers: asynchronously reset.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage datapath registers.
    // ------------------------------------------------------------------
    // NOTE: these carry no reset; their contents only matter while the
    // matching valid bit is set, and leaving reset off keeps the wide
    // datapath free of reset fan-out.
    always_ff @(posedge clk) begin
        g_q   <= g_d;
        p_q   <= p_d;
        x_q   <= x_d;
        c0_q  <= c0_d;
        tag_q <= tag_d;
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_tag   = out_tag_q;

endmodule

// File: doc/prefix_adder_pipe.md
PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width; power of two, 4..64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 Derived constant LEVELS = clog2(WIDTH), the number of Kogge-Stone prefix levels (5 at WIDTH=32).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 in_valid  input  1  operand presented.
REQ-008 in_ready  output  1  block accepts operand this cycle.
REQ-009 a, b  input  WIDTH  operands.
REQ-010 cin  input  1  carry-in; ignored when sub=1.
REQ-011 sub  input  1  0 = a+b+cin, 1 = a-b.
REQ-012 in_tag  input  TAG_W  sideband tag, returned unchanged.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 sum  output  WIDTH  result.
REQ-016 cout  output  1  carry out of bit WIDTH-1.
REQ-017 ovf  output  1  signed overflow.
REQ-018 out_tag  output  TAG_W  tag of the operation in sum.

Function
REQ-019 Operand SHALL be accepted on a rising edge where in_valid=1, in_ready=1 and flush=0.
REQ-020 Stage S0 SHALL register per-bit generate/propagate (kill implied) of a and b' (b'=~b if sub, else b), with the effective carry-in (1 if sub, else cin) folded into bit 0: g0 = g0 | (p0 & c_eff).
REQ-021 Stages S1..S(LEVELS) SHALL each register one Kogge-Stone level at span 2^(k-1): kill dominates; propagate takes the value of the lower position; generate stays generate.
REQ-022 The output register SHALL hold sum[i] = p[i] ^ c[i], cout = c[WIDTH], ovf = c[WIDTH-1] ^ c[WIDTH].
REQ-023 Latency: an operand accepted on edge N SHALL be presented with out_valid=1 after edge N+LEVELS+1 (N+6 at WIDTH=32) when no stall occurs.
REQ-024 Advance condition adv = !out_valid | out_ready; all stages SHALL shift together only when adv=1; in_ready SHALL equal adv.
REQ-025 While adv=0 every stage, including out_*, SHALL hold its value; no operation SHALL be lost or duplicated.
REQ-026 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-027 Results SHALL leave in acceptance order, each with its own tag.
REQ-028 flush=1 SHALL clear every stage valid bit and out_valid on that edge and SHALL take priority over a simultaneous accept, which is discarded.
REQ-029 Data registers of invalid stages are don't-care; sum/cout/ovf/out_tag are defined only while out_valid=1.

Reset
REQ-030 rst=1 SHALL immediately clear all stage valid bits, out_valid, sum, cout, ovf and out_tag to 0, regardless of clk.
REQ-031 In-flight operations SHALL be discarded; no result from before reset SHALL appear after rst deasserts.
REQ-032 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-033 With macro PREFIX_ADDER_SAT_EN defined, on ovf=1 sum SHALL saturate: positive overflow gives 0x7F..F, negative overflow gives 0x80..0; ovf and cout are reported unchanged.
REQ-034 Without PREFIX_ADDER_SAT_EN, sum SHALL wrap modulo 2^WIDTH; latency is identical in both builds.

Verification (WIDTH=32)
REQ-035 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, accepted at edge N -> out_valid at N+6, sum=0x00000000, cout=1, ovf=0.
REQ-036 a=0x7FFFFFFF, b=0x00000001, sub=0 -> ovf=1; sum=0x80000000 without the macro, 0x7FFFFFFF with it.
REQ-037 sub=1, a=5, b=7, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0 (cin ignored).
REQ-038 8 back-to-back operations with tags 0..7, out_ready low for 3 cycles mid-stream -> in_ready low during the stall, all 8 results in tag order, no gaps or duplicates.
REQ-039 rst pulsed with 3 operations in flight -> out_valid=0 immediately, no result output after release, next operation has latency 6.
REQ-040 flush=1 together with in_valid=1 (tag 9) and 2 operations in flight -> no result with tag 9 or either earlier tag is ever output.
